// File: rtl/load_store_unit.sv
// load_store_unit: byte-addressed RV32 load/store front end for a word-organised
// data memory with asynchronous read and clocked write. Sub-word stores are done
// as read-modify-write. Optional macro LSU_MISALIGN_TRAP_EN turns misaligned
// halfword/word accesses into faults; without it they are performed as aligned.
module load_store_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_fault,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    output logic                  mem_read,
    output logic                  mem_write,
    input  logic [DATA_WIDTH-1:0] mem_dout
);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t                  state;
    logic                    wr_q;
    logic [2:0]              f3_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic                    rd_en_q;
    logic                    wr_en_q;

    logic                    illegal;
    logic                    misalign;
    logic                    fault;
    logic [7:0]              byte_sel;
    logic [15:0]             half_sel;
    logic [DATA_WIDTH-1:0]   load_ext;
    logic [DATA_WIDTH-1:0]   merged;

    // Memory strobes drop immediately on reset so an in-flight write is never committed.
    assign mem_read  = rd_en_q & ~reset;
    assign mem_write = wr_en_q & ~reset;

    // Classify the incoming request before it is accepted.
    always_comb begin
        illegal  = req_write ? (req_funct3 > 3'b010)
                             : (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11);
        misalign = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                   (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
`ifdef LSU_MISALIGN_TRAP_EN
        fault    = illegal | misalign;
`else
        fault    = illegal;
`endif
    end

    // Pick the addressed byte/half out of the read word and extend it.
    always_comb begin
        byte_sel = mem_dout[{addr_q[1:0], 3'b000} +: 8];
        half_sel = mem_dout[{addr_q[1], 4'b0000} +: 16];
        case (f3_q)
            3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_ext = {24'd0, byte_sel};
            3'b101:  load_ext = {16'd0, half_sel};
            default: load_ext = mem_dout;
        endcase
    end

    // Splice the store byte/half into the word read back during RD.
    always_comb begin
        merged = mem_dout;
        if (f3_q[1:0] == 2'b00)
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        else
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end

    // Request FSM with all interface outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_fault <= 1'b0;
            rd_en_q    <= 1'b0;
            wr_en_q    <= 1'b0;
            mem_addr   <= '0;
            mem_din    <= '0;
            wr_q       <= 1'b0;
            f3_q       <= 3'b000;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        wr_q      <= req_write;
                        f3_q      <= req_funct3;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        req_ready <= 1'b0;
                        if (fault) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_fault <= 1'b1;
                            resp_rdata <= '0;
                        end else if (req_write && req_funct3 == 3'b010) begin
                            state    <= WR;
                            wr_en_q  <= 1'b1;
                            mem_din  <= req_wdata;
                            mem_addr <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                        end else begin
                            state    <= RD;
                            rd_en_q  <= 1'b1;
                            mem_addr <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                        end
                    end
                end
                RD: begin
                    rd_en_q <= 1'b0;
                    if (wr_q) begin
                        state   <= WR;
                        wr_en_q <= 1'b1;
                        mem_din <= merged;
                    end else begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_fault <= 1'b0;
                        resp_rdata <= load_ext;
                        mem_addr   <= '0;
                    end
                end
                WR: begin
                    wr_en_q    <= 1'b0;
                    state      <= RESP;
                    resp_valid <= 1'b1;
                    resp_fault <= 1'b0;
                    resp_rdata <= '0;
                    mem_addr   <= '0;
                end
                default: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    resp_fault <= 1'b0;
                    resp_rdata <= '0;
                    req_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed requests push expected
// responses; a negedge monitor pops and compares on every resp_valid.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_dout;

    load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_read(mem_read),
        .mem_write(mem_write), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    // Word memory: asynchronous read, write on posedge.
    logic [31:0] mem [0:255];
    assign mem_dout = mem[mem_addr[9:2]];
    always @(posedge clk) if (mem_write) mem[mem_addr[9:2]] <= mem_din;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        int          lat;
        int          nrd;
        int          nwr;
        logic [31:0] din;
    } exp_t;

    exp_t q[$];
    int   acc_q[$];
    int   cyc = 0;
    int   rd_cnt = 0, wr_cnt = 0;
    int   prev_resp = 0, last_resp = 0;
    int   checks = 0, errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: count strobes, check write data and responses.
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_read) rd_cnt++;
            if (mem_write) begin
                wr_cnt++;
                if (q.size() > 0) chk("mem_din", mem_din, q[0].din);
            end
            if (mem_read || resp_valid) chk("ready_low", {31'd0, req_ready}, 32'd0);
            if (resp_valid) begin
                prev_resp = last_resp;
                last_resp = cyc;
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_resp: resp_valid with empty scoreboard (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    int   a;
                    e = q.pop_front();
                    a = acc_q.pop_front();
                    chk("rdata", resp_rdata, e.rdata);
                    chk("fault", {31'd0, resp_fault}, {31'd0, e.fault});
                    chk("latency", cyc - a + 1, e.lat);
                    chk("rd_cycles", rd_cnt, e.nrd);
                    chk("wr_cycles", wr_cnt, e.nwr);
                end
            end
        end
    end

    // Wait for req_ready, drive, and record the accept; optionally keep req_valid high.
    task automatic issue(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic push, input logic hold,
                         input exp_t e);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++; errors++;
            $display("FAIL ready_timeout: req_ready never rose (cycle %0d)", cyc);
        end
        req_valid  = 1'b1;
        req_write  = wr;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        rd_cnt = 0;
        wr_cnt = 0;
        if (push) begin
            q.push_back(e);
            acc_q.push_back(cyc);
        end
        if (!hold) req_valid = 1'b0;
    endtask

    function automatic exp_t mk(input logic [31:0] rd, input logic f, input int lat,
                                input int nrd, input int nwr, input logic [31:0] din);
        exp_t e;
        e.rdata = rd; e.fault = f; e.lat = lat; e.nrd = nrd; e.nwr = nwr; e.din = din;
        return e;
    endfunction

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (q.size() > 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: %0d responses missing", q.size());
            q.delete();
            acc_q.delete();
        end
    endtask

    logic [31:0] w8;
    exp_t        e;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        mem[64] = 32'h8899AABB;
        mem[65] = 32'h11223344;
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0;
        req_funct3 = 3'b000; req_addr = 32'd0; req_wdata = 32'd0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_fault", {31'd0, resp_fault}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_din", mem_din, 32'd0);
        chk("rst_strobes", {30'd0, mem_read, mem_write}, 32'd0);

        // Loads with extraction
        issue(0, 3'b000, 32'h101, 0, 1, 0, mk(32'hFFFFFFAA, 0, 2, 1, 0, 0)); drain();
        issue(0, 3'b100, 32'h103, 0, 1, 0, mk(32'h00000088, 0, 2, 1, 0, 0)); drain();
        issue(0, 3'b101, 32'h102, 0, 1, 0, mk(32'h00008899, 0, 2, 1, 0, 0)); drain();
        issue(0, 3'b001, 32'h102, 0, 1, 0, mk(32'hFFFF8899, 0, 2, 1, 0, 0)); drain();
        issue(0, 3'b010, 32'h100, 0, 1, 0, mk(32'h8899AABB, 0, 2, 1, 0, 0)); drain();

        // Byte store read-modify-write
        issue(1, 3'b000, 32'h102, 32'h12345677, 1, 0, mk(0, 0, 3, 1, 1, 32'h8877AABB)); drain();
        issue(0, 3'b010, 32'h100, 0, 1, 0, mk(32'h8877AABB, 0, 2, 1, 0, 0)); drain();

        // Misaligned halfword store
`ifdef LSU_MISALIGN_TRAP_EN
        w8 = 32'h8877AABB;
        issue(1, 3'b001, 32'h101, 32'h0000CAFE, 1, 0, mk(0, 1, 1, 0, 0, 0)); drain();
        issue(0, 3'b010, 32'h102, 0, 1, 0, mk(0, 1, 1, 0, 0, 0)); drain();
`else
        w8 = 32'h8877CAFE;
        issue(1, 3'b001, 32'h101, 32'h0000CAFE, 1, 0, mk(0, 0, 3, 1, 1, 32'h8877CAFE)); drain();
        issue(0, 3'b010, 32'h102, 0, 1, 0, mk(32'h8877CAFE, 0, 2, 1, 0, 0)); drain();
`endif
        issue(0, 3'b010, 32'h100, 0, 1, 0, mk(w8, 0, 2, 1, 0, 0)); drain();

        // Illegal funct3 faults in both builds
        issue(0, 3'b011, 32'h100, 0, 1, 0, mk(0, 1, 1, 0, 0, 0)); drain();
        issue(0, 3'b111, 32'h100, 0, 1, 0, mk(0, 1, 1, 0, 0, 0)); drain();
        issue(1, 3'b100, 32'h100, 32'hFFFFFFFF, 1, 0, mk(0, 1, 1, 0, 0, 0)); drain();

        // Full word store, no read
        issue(1, 3'b010, 32'h104, 32'h55667788, 1, 0, mk(0, 0, 2, 0, 1, 32'h55667788)); drain();
        issue(0, 3'b010, 32'h104, 0, 1, 0, mk(32'h55667788, 0, 2, 1, 0, 0)); drain();

        // Reset during WR: write dropped, no response
        issue(1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, mk(0, 0, 0, 0, 0, 0));
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_wr_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_wr_no_write", wr_cnt, 32'd0);
        repeat (4) @(negedge clk);
        issue(0, 3'b010, 32'h100, 0, 1, 0, mk(w8, 0, 2, 1, 0, 0)); drain();

        // Back-to-back with req_valid held high
        issue(0, 3'b010, 32'h100, 0, 1, 1, mk(w8, 0, 2, 1, 0, 0));
        issue(0, 3'b010, 32'h104, 0, 1, 0, mk(32'h55667788, 0, 2, 1, 0, 0));
        drain();
        chk("b2b_spacing", last_resp - prev_resp, 32'd3);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
